// File: rtl/semafor_pkg.sv
// semafor_pkg: shared types and constants for the Semafor traffic-light controller.
//   state_t       - phase FSM state encoding (RED, RED_YEL, GREEN, YEL, NIGHT)
//   PH_W          - phase counter width
//   DEF_*         - default phase durations (ticks) and prescaler ratio
//   clamp_dur()   - maps a duration parameter into the legal 1..255 range
package semafor_pkg;

    localparam int PH_W = 8;

    localparam int DEF_TICK_DIV    = 50;
    localparam int DEF_T_RED       = 30;
    localparam int DEF_T_RED_YEL   = 3;
    localparam int DEF_T_GREEN     = 25;
    localparam int DEF_T_YEL       = 4;
    localparam int DEF_T_MIN_GREEN = 10;

    typedef enum logic [2:0] {
        ST_RED     = 3'd0,
        ST_RED_YEL = 3'd1,
        ST_GREEN   = 3'd2,
        ST_YEL     = 3'd3,
        ST_NIGHT   = 3'd4
    } state_t;

    // A zero duration would make the phase-end compare wrap to 255, so zero
    // is forced up to one tick; anything wider than the counter saturates.
    function automatic logic [PH_W-1:0] clamp_dur(input int d);
        if (d < 1)
            return PH_W'(1);
        else if (d > 255)
            return PH_W'(255);
        else
            return PH_W'(d);
    endfunction

endpackage

// File: rtl/semafor_ctrl_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
//   clk    in  - clock, rising edge
//   rst_n  in  - asynchronous reset, active low (counter restarts at 0)
//   tick   out - high on the cycle where the divider count equals TICK_DIV-1
// With TICK_DIV=1 the counter stays at 0 and tick is permanently high.
module tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = (TICK_DIV < 1) ? 1 : ((TICK_DIV > 65535) ? 65535 : TICK_DIV);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 16'd1;
    end

endmodule

// File: rtl/semafor_ctrl.sv
// semafor_ctrl: traffic-light phase controller with night flashing-yellow mode.
//   clk      in  - clock, rising edge
//   rst_n    in  - asynchronous reset, active low
//   night    in  - level request for night flashing mode
//   ped_req  in  - pedestrian request (pulse or level)
//   blink_q  in  - Q of the external toggle flip-flop
//   blink_t  out - one-cycle toggle pulse to the external flip-flop (NIGHT only)
//   red, yellow, green out - lamp drives, Moore-decoded from the state register
// Optional build macro SEMAFOR_PED_EN: compiles in the pedestrian request
// latch and the early GREEN exit. Without it ped_req is ignored.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int T_RED       = DEF_T_RED,
    parameter int T_RED_YEL   = DEF_T_RED_YEL,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_YEL       = DEF_T_YEL,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic night,
    input  logic ped_req,
    input  logic blink_q,
    output logic blink_t,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam logic [PH_W-1:0] LAST_RED     = clamp_dur(T_RED) - 1'b1;
    localparam logic [PH_W-1:0] LAST_RED_YEL = clamp_dur(T_RED_YEL) - 1'b1;
    localparam logic [PH_W-1:0] LAST_GREEN   = clamp_dur(T_GREEN) - 1'b1;
    localparam logic [PH_W-1:0] LAST_YEL     = clamp_dur(T_YEL) - 1'b1;

    logic            tick;
    state_t          state;
    state_t          state_next;
    logic [PH_W-1:0] ph_cnt;
    logic [PH_W-1:0] ph_last;
    logic            ph_end;
    logic            ped_exit;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Last count value of the current phase. NIGHT has no length, so its
    // compare value is the counter maximum and the counter simply wraps.
    always_comb begin
        ph_last = '1;
        case (state)
            ST_RED:     ph_last = LAST_RED;
            ST_RED_YEL: ph_last = LAST_RED_YEL;
            ST_GREEN:   ph_last = LAST_GREEN;
            ST_YEL:     ph_last = LAST_YEL;
            default:    ph_last = '1;
        endcase
    end

    assign ph_end = (ph_cnt == ph_last);

`ifdef SEMAFOR_PED_EN
    localparam logic [PH_W-1:0] LAST_MIN_GREEN = clamp_dur(T_MIN_GREEN) - 1'b1;

    logic ped_pend;

    assign ped_exit = ped_pend && (ph_cnt >= LAST_MIN_GREEN);

    // Clearing wins over a same-cycle request: a request that arrives while
    // the FSM is heading into YEL or NIGHT is already served or discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ped_pend <= 1'b0;
        else if ((state_next == ST_YEL && state != ST_YEL) ||
                 state == ST_NIGHT || state_next == ST_NIGHT)
            ped_pend <= 1'b0;
        else if (ped_req)
            ped_pend <= 1'b1;
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_exit       = 1'b0;
`endif

    // Next-state: transitions only on a tick; night beats phase end and
    // pedestrian early exit.
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_RED: begin
                    if (night)       state_next = ST_NIGHT;
                    else if (ph_end) state_next = ST_RED_YEL;
                end
                ST_RED_YEL: begin
                    if (night)       state_next = ST_NIGHT;
                    else if (ph_end) state_next = ST_GREEN;
                end
                ST_GREEN: begin
                    if (night)                  state_next = ST_NIGHT;
                    else if (ph_end || ped_exit) state_next = ST_YEL;
                end
                ST_YEL: begin
                    if (night)       state_next = ST_NIGHT;
                    else if (ph_end) state_next = ST_RED;
                end
                ST_NIGHT: begin
                    if (!night)      state_next = ST_RED;
                end
                default: state_next = ST_RED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RED;
        else
            state <= state_next;
    end

    // Every state change restarts the phase count, so an early exit or a
    // night entry still gives the next phase its full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ph_cnt <= '0;
        else if (state_next != state)
            ph_cnt <= '0;
        else if (tick)
            ph_cnt <= ph_end ? '0 : ph_cnt + 1'b1;
    end

    always_comb begin
        red     = 1'b0;
        yellow  = 1'b0;
        green   = 1'b0;
        blink_t = 1'b0;
        case (state)
            ST_RED:     red = 1'b1;
            ST_RED_YEL: begin
                red    = 1'b1;
                yellow = 1'b1;
            end
            ST_GREEN:   green = 1'b1;
            ST_YEL:     yellow = 1'b1;
            ST_NIGHT: begin
                yellow  = blink_q;
                blink_t = tick;
            end
            default:    red = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_semafor_ctrl.sv
module tb_semafor_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic night = 1'b0;
    logic ped_req = 1'b0;
    logic blink_q;
    logic blink_t;
    logic red;
    logic yellow;
    logic green;
    logic [2:0] lamps;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_RY  = 3'b110;
    localparam logic [2:0] C_GRN = 3'b001;
    localparam logic [2:0] C_YEL = 3'b010;

`ifdef SEMAFOR_PED_EN
    localparam int PED_GREEN = 8;
`else
    localparam int PED_GREEN = 20;
`endif

    typedef struct {
        string      tag;
        logic [2:0] code;
        int         len;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign lamps = {red, yellow, green};

    // Toggle flip-flop as wired by the parent design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blink_q <= 1'b0;
        else if (blink_t)
            blink_q <= ~blink_q;
    end

    semafor_ctrl #(
        .TICK_DIV    (TD),
        .T_RED       (3),
        .T_RED_YEL   (1),
        .T_GREEN     (5),
        .T_YEL       (2),
        .T_MIN_GREEN (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .night   (night),
        .ped_req (ped_req),
        .blink_q (blink_q),
        .blink_t (blink_t),
        .red     (red),
        .yellow  (yellow),
        .green   (green)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] code, input int len);
        exp_t e;
        e.tag  = tag;
        e.code = code;
        e.len  = len;
        sb.push_back(e);
    endtask

    // Called at a negedge sample inside a lamp segment; measures how many
    // more samples the lamp pattern holds and compares with the queue head.
    task automatic check_seg();
        exp_t e;
        int   n;
        logic bt;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
            return;
        end
        e  = sb.pop_front();
        n  = 0;
        bt = 1'b0;
        chk({e.tag, "_lamps"}, 32'(lamps), 32'(e.code));
        while (lamps === e.code && n < 300) begin
            bt = bt | blink_t;
            n++;
            @(negedge clk);
        end
        chk({e.tag, "_len"}, 32'(n), 32'(e.len));
        chk({e.tag, "_blink_t"}, 32'(bt), 32'(0));
        $display("[TB] segment %s lamps=%b cycles=%0d", e.tag, e.code, n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_lamps", 32'(lamps), 32'(C_RED));
        chk("reset_blink_t", 32'(blink_t), 32'(0));

        // Full normal cycle from reset release: 12 + 4 + 20 + 8 = 44 cycles
        rst_n = 1'b1;
        push("red0", C_RED, 12);
        push("ry0", C_RY, 4);
        push("green0", C_GRN, 20);
        push("yel0", C_YEL, 8);
        push("red1", C_RED, 12);
        repeat (5) check_seg();

        // Night requested mid-GREEN: GREEN ends at the next tick
        push("ry1", C_RY, 4);
        check_seg();
        repeat (6) @(negedge clk);
        night = 1'b1;
        push("green_to_night", C_GRN, 2);
        check_seg();

        // Flashing: blink_t every 4th cycle, yellow toggles every 4 cycles
        for (int i = 0; i < 20; i++) begin
            if (i == 16) night = 1'b0;
            chk($sformatf("night_rg_%0d", i), 32'({red, green}), 32'(0));
            chk($sformatf("night_blink_t_%0d", i), 32'(blink_t), 32'((i % 4) == 3));
            chk($sformatf("night_yel_%0d", i), 32'(yellow), 32'((i / 4) % 2));
            @(negedge clk);
        end

        // Night exit: RED runs its full length, no more blink pulses
        push("red_after_night", C_RED, 12);
        push("ry2", C_RY, 4);
        push("green2", C_GRN, 20);
        push("yel2", C_YEL, 8);
        repeat (4) check_seg();

        // Pedestrian pulse during RED shortens the following GREEN
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        push("red_ped", C_RED, 11);
        push("ry_ped", C_RY, 4);
        push("green_ped", C_GRN, PED_GREEN);
        push("yel_ped", C_YEL, 8);
        repeat (4) check_seg();

        // Night and pedestrian on the same tick in GREEN
        push("red3", C_RED, 12);
        push("ry3", C_RY, 4);
        repeat (2) check_seg();
        repeat (3) @(negedge clk);
        night   = 1'b1;
        ped_req = 1'b1;
        push("green_night_ped", C_GRN, 1);
        check_seg();
        ped_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) night = 1'b0;
            chk($sformatf("night2_rg_%0d", i), 32'({red, green}), 32'(0));
            chk($sformatf("night2_yel_%0d", i), 32'(yellow), 32'(blink_q));
            @(negedge clk);
        end
        push("red4", C_RED, 12);
        push("ry4", C_RY, 4);
        push("green4_full", C_GRN, 20);
        repeat (3) check_seg();

        // Reset asserted mid-YEL takes effect immediately
        repeat (3) @(negedge clk);
        chk("yel_before_reset", 32'(lamps), 32'(C_YEL));
        rst_n = 1'b0;
        #1;
        chk("async_reset_lamps", 32'(lamps), 32'(C_RED));
        chk("async_reset_blink_t", 32'(blink_t), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        push("red_after_reset", C_RED, 12);
        push("ry_after_reset", C_RY, 4);
        repeat (2) check_seg();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
